lfsr_prng_stream: RTL and testbench

Parametrised Fibonacci-LFSR pseudo-random word generator with a programmable tap mask, run-time seed loading, zero-state lockup protection and a valid/ready output stream. It replaces the fixed-width, free-running, all-taps LFSR pair in the PRNG layer. Consumers such as stimulus mixers and noise injectors pull one OUT_W-bit word at a time under back-pressure.

---
 rtl/lfsr_prng_stream.sv | 116 +++++++++++
 tb/tb_lfsr_prng_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prng_stream.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_prng_stream
// Purpose  : Fibonacci LFSR word generator with programmable taps, seed load,
//            zero-seed lockup protection and a valid/ready output stream.
//            Optional wrap detector enabled by macro LFSR_WRAP_DET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_prng_stream #(
  parameter int unsigned       WIDTH = 16,
  parameter int unsigned       OUT_W = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]  INIT  = 16'h0001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             lockup,
  output logic             wrap
);

  localparam int unsigned      CNT_W    = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] C_LAST   = CNT_W'(OUT_W - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_t;

  fsm_t             r_fsm;
  logic [WIDTH-1:0] r_lfsr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_seed_zero;
  logic [WIDTH-1:0] w_seed_val;

  assign w_fb        = ^(r_lfsr & TAPS);
  assign w_next      = {r_lfsr[WIDTH-2:0], w_fb};
  assign w_seed_zero = (seed == '0);
  // A zero seed would freeze the LFSR forever, so INIT stands in for it.
  assign w_seed_val  = w_seed_zero ? INIT : seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= FILL;
      r_lfsr    <= INIT;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      lockup    <= 1'b0;
    end else begin
      lockup <= seed_load & w_seed_zero;
      if (seed_load) begin
        // Seed load wins over everything; a word handshaking this cycle is
        // still consumed by the consumer, any other held word is dropped.
        r_lfsr    <= w_seed_val;
        r_cnt     <= '0;
        r_fsm     <= FILL;
        out_valid <= 1'b0;
      end else begin
        case (r_fsm)
          FILL: begin
            if (en) begin
              r_lfsr <= w_next;
              if (r_cnt == C_LAST) begin
                out_data  <= w_next[OUT_W-1:0];
                out_valid <= 1'b1;
                r_cnt     <= '0;
                r_fsm     <= HOLD;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              r_fsm     <= FILL;
            end
          end
          default: r_fsm <= FILL;
        endcase
      end
    end
  end

`ifdef LFSR_WRAP_DET_EN
  logic [WIDTH-1:0] r_ref;
  logic             w_step;

  assign w_step = !seed_load && (r_fsm == FILL) && en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= INIT;
      wrap  <= 1'b0;
    end else begin
      wrap <= w_step && (w_next == r_ref);
      if (seed_load) begin
        r_ref <= w_seed_val;
      end
    end
  end
`else
  assign wrap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prng_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_prng_stream
// Purpose  : Scoreboard bench for lfsr_prng_stream (default and 4-bit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_prng_stream;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [15:0] seed;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        lockup;
  logic        wrap;

  logic        rst_n_s;
  logic        en_s;
  logic        seed_load_s;
  logic [3:0]  seed_s;
  logic        out_valid_s;
  logic        out_ready_s;
  logic [0:0]  out_data_s;
  logic        lockup_s;
  logic        wrap_s;

  int          n_cmp;
  int          n_bad;
  logic [15:0] m_state;
  logic [7:0]  q[$];

  lfsr_prng_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .lockup    (lockup),
    .wrap      (wrap)
  );

  lfsr_prng_stream #(
    .WIDTH (4),
    .OUT_W (1),
    .TAPS  (4'hC),
    .INIT  (4'h1)
  ) dut_small (
    .clk       (clk),
    .rst_n     (rst_n_s),
    .en        (en_s),
    .seed_load (seed_load_s),
    .seed      (seed_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .out_data  (out_data_s),
    .lockup    (lockup_s),
    .wrap      (wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: OUT_W=8 steps of x^16+x^14+x^13+x^11+1.
  task automatic model_word(output logic [7:0] w);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb      = ^(m_state & 16'hB400);
      m_state = {m_state[14:0], fb};
    end
    w = m_state[7:0];
  endtask

  task automatic push_word();
    logic [7:0] w;
    model_word(w);
    q.push_back(w);
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset(input logic e, input logic r);
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed      = 16'h0000;
    en        = e;
    out_ready = r;
    tick();
    tick();
    rst_n   = 1'b1;
    m_state = 16'h0001;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    n_cmp++; if (lockup !== 1'b0) begin n_bad++; $display("FAIL reset_lockup: got %b want 0", lockup); end
    n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    rst_n = 1'b1;
  endtask

  task automatic test_first_words();
    int         n;
    logic [7:0] exp;
    do_reset(1'b1, 1'b1);
    push_word();
    wait_valid(40, n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL first_latency: got %0d want 8", n); end
    exp = q.pop_front();
    n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL first_word: got %h want %h", out_data, exp); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_one_cycle: got %b want 0", out_valid); end
    push_word();
    wait_valid(40, n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL second_latency: got %0d want 8", n); end
    exp = q.pop_front();
    n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL second_word: got %h want %h", out_data, exp); end
    n_cmp++; if (out_data !== 8'h2D) begin n_bad++; $display("FAIL second_word_const: got %h want 2d", out_data); end
  endtask

  task automatic test_backpressure();
    int         n;
    logic [7:0] exp;
    do_reset(1'b1, 1'b0);
    push_word();
    wait_valid(40, n);
    n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL bp_latency: got %0d want 8", n); end
    exp = q.pop_front();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b data=%h want valid=1 data=%h", i, out_valid, out_data, exp);
      end
    end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", out_valid); end
    push_word();
    wait_valid(40, n);
    exp = q.pop_front();
    n_cmp++; if (n !== 8 || out_data !== exp) begin n_bad++; $display("FAIL bp_next_word: got n=%0d data=%h want n=8 data=%h", n, out_data, exp); end
  endtask

  task automatic test_lockup();
    int         n;
    logic [7:0] exp;
    do_reset(1'b1, 1'b1);
    tick(); tick(); tick();
    seed_load = 1'b1;
    seed      = 16'h0000;
    tick();
    seed_load = 1'b0;
    n_cmp++; if (lockup !== 1'b1) begin n_bad++; $display("FAIL lockup_pulse: got %b want 1", lockup); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL lockup_valid: got %b want 0", out_valid); end
    m_state = 16'h0001;
    push_word();
    tick();
    n_cmp++; if (lockup !== 1'b0) begin n_bad++; $display("FAIL lockup_single: got %b want 0", lockup); end
    wait_valid(40, n);
    exp = q.pop_front();
    n_cmp++; if (n + 1 !== 8 || out_data !== exp) begin n_bad++; $display("FAIL lockup_word: got n=%0d data=%h want n=8 data=%h", n + 1, out_data, exp); end
  endtask

  task automatic test_en_gap();
    int         n;
    logic [7:0] exp;
    do_reset(1'b1, 1'b1);
    push_word();
    wait_valid(40, n);
    exp = q.pop_front();
    n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL gap_first: got %h want %h", out_data, exp); end
    tick();
    push_word();
    tick(); tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gap_frozen: got %b want 0", out_valid); end
    en = 1'b1;
    wait_valid(40, n);
    exp = q.pop_front();
    n_cmp++; if (n + 8 !== 13) begin n_bad++; $display("FAIL gap_latency: got %0d want 13", n + 8); end
    n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL gap_word: got %h want %h", out_data, exp); end
  endtask

  task automatic test_seed_handshake();
    int         n;
    logic [7:0] exp;
    do_reset(1'b1, 1'b0);
    push_word();
    wait_valid(40, n);
    exp = q.pop_front();
    n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL sh_word: got %h want %h", out_data, exp); end
    out_ready = 1'b1;
    seed_load = 1'b1;
    seed      = 16'hACE1;
    tick();
    seed_load = 1'b0;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || lockup !== 1'b0) begin n_bad++; $display("FAIL sh_consume: got valid=%b lockup=%b want 0 0", out_valid, lockup); end
    m_state = 16'hACE1;
    push_word();
    wait_valid(40, n);
    exp = q.pop_front();
    n_cmp++; if (n !== 8 || out_data !== exp) begin n_bad++; $display("FAIL sh_seeded_word: got n=%0d data=%h want n=8 data=%h", n, out_data, exp); end
    seed_load = 1'b1;
    seed      = 16'h1234;
    tick();
    seed_load = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL sh_discard: got %b want 0", out_valid); end
    m_state = 16'h1234;
    push_word();
    wait_valid(40, n);
    exp = q.pop_front();
    n_cmp++; if (n !== 8 || out_data !== exp) begin n_bad++; $display("FAIL sh_discard_word: got n=%0d data=%h want n=8 data=%h", n, out_data, exp); end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset(1'b1, 1'b0);
    push_word();
    wait_valid(40, n);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ar_pre: got %b want 1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin n_bad++; $display("FAIL ar_immediate: got valid=%b data=%h want 0 00", out_valid, out_data); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    int cnt;
    int first;
    int last;
    int gap_bad;
    en_s        = 1'b1;
    out_ready_s = 1'b1;
    seed_load_s = 1'b0;
    seed_s      = 4'h0;
    rst_n_s     = 1'b0;
    tick();
    rst_n_s = 1'b1;
    cnt     = 0;
    first   = -1;
    last    = -1;
    gap_bad = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (wrap_s === 1'b1) begin
        if (first < 0) first = i;
        if (last >= 0 && i - last != 30) gap_bad++;
        last = i;
        cnt++;
      end
    end
`ifdef LFSR_WRAP_DET_EN
    n_cmp++; if (cnt !== 3) begin n_bad++; $display("FAIL wrap_count: got %0d want 3", cnt); end
    n_cmp++; if (first !== 29) begin n_bad++; $display("FAIL wrap_first: got %0d want 29", first); end
    n_cmp++; if (gap_bad !== 0) begin n_bad++; $display("FAIL wrap_period: got %0d bad gaps want 0", gap_bad); end
`else
    n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL wrap_absent: got %0d pulses want 0", cnt); end
`endif
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    rst_n_s     = 1'b0;
    en          = 1'b0;
    en_s        = 1'b0;
    seed_load   = 1'b0;
    seed_load_s = 1'b0;
    seed        = 16'h0000;
    seed_s      = 4'h0;
    out_ready   = 1'b0;
    out_ready_s = 1'b0;
    m_state     = 16'h0001;
    test_reset();
    test_first_words();
    test_backpressure();
    test_lockup();
    test_en_gap();
    test_seed_handshake();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
